// File: rtl/core_seq_if.sv
// Command and core-side strobe bundle for core_seq. The host/environment side
// uses the master modport; the sequencer itself uses the slave modport.
interface core_seq_if #(
  parameter int addr_w = 11,
  parameter int len_w  = 12
);
  // Command handshake: a command transfers on a rising edge where cmd_valid
  // and cmd_ready are both high; cmd_ready is only ever high in IDLE.
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic              cmd_mode;
  logic [addr_w-1:0] cmd_xbase;
  logic [addr_w-1:0] cmd_pbase;
  logic [len_w-1:0]  cmd_len;
  logic              l0_full;
  logic              ofifo_valid;
  logic              xmem_cen;
  logic              xmem_wen;
  logic [addr_w-1:0] xmem_addr;
  logic              pmem_cen;
  logic              pmem_wen;
  logic [addr_w-1:0] pmem_addr;
  logic              l0_wr;
  logic              kload;
  logic              execute;
  logic              ofifo_rd;
  logic              sfp_valid;
  logic              mode_select;
  logic              busy;
  logic              done;

  modport master (
    output cmd_valid, cmd_op, cmd_mode, cmd_xbase, cmd_pbase, cmd_len,
           l0_full, ofifo_valid,
    input  cmd_ready, xmem_cen, xmem_wen, xmem_addr, pmem_cen, pmem_wen,
           pmem_addr, l0_wr, kload, execute, ofifo_rd, sfp_valid,
           mode_select, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_mode, cmd_xbase, cmd_pbase, cmd_len,
           l0_full, ofifo_valid,
    output cmd_ready, xmem_cen, xmem_wen, xmem_addr, pmem_cen, pmem_wen,
           pmem_addr, l0_wr, kload, execute, ofifo_rd, sfp_valid,
           mode_select, busy, done
  );
endinterface

// File: rtl/core_seq.sv
// Command-driven sequencer for the systolic core (WS/OS dataflows).
// Define CORE_SEQ_PERF_EN to add saturating busy/stall performance counters.
module core_seq #(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int addr_w = 11,
  parameter int len_w  = 12
) (
  input  logic        clk,
  input  logic        reset,
  core_seq_if.slave   bus,
  output logic [1:0]  dbg_state_o
`ifdef CORE_SEQ_PERF_EN
  ,
  output logic [31:0] perf_busy_cyc,
  output logic [31:0] perf_stall_cyc
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_TAIL, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_NOP, OP_XLOAD, OP_L0FILL, OP_KLOAD, OP_EXEC, OP_DRAIN, OP_READOUT, OP_RSVD
  } op_e;

  localparam logic [len_w-1:0] OS_FLUSH = len_w'(row + col - 2);

  state_e            state_q, state_d;
  op_e               op_q;
  logic              mode_q;
  logic [addr_w-1:0] xbase_q, pbase_q;
  logic [len_w-1:0]  len_q;
  logic [len_w-1:0]  cnt_q, cnt_d;
  logic              l0_wr_q, sfp_q, rdy_q;

  logic              accept;
  logic              issue;
  logic              last_beat;
  logic [len_w-1:0]  tail_len;
  logic [addr_w-1:0] x_at, p_at;

  assign bus.cmd_ready = (state_q == S_IDLE) && rdy_q;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign last_beat     = (cnt_q == len_q - 1'b1);
  assign x_at          = xbase_q + addr_w'(cnt_q);
  assign p_at          = pbase_q + addr_w'(cnt_q);

  // Cycles spent in TAIL after the last beat: one for the delayed read
  // strobes, row+col-2 for the OS accumulation flush.
  always_comb begin
    tail_len = '0;
    case (op_q)
      OP_L0FILL, OP_READOUT: tail_len = len_w'(1);
      OP_EXEC:               tail_len = mode_q ? OS_FLUSH : '0;
      default:               tail_len = '0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    issue         = 1'b0;
    bus.xmem_cen  = 1'b1;
    bus.xmem_wen  = 1'b1;
    bus.xmem_addr = '0;
    bus.pmem_cen  = 1'b1;
    bus.pmem_wen  = 1'b1;
    bus.pmem_addr = '0;
    bus.kload     = 1'b0;
    bus.execute   = 1'b0;
    bus.ofifo_rd  = 1'b0;
    bus.done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (bus.cmd_len == '0 || bus.cmd_op == 3'd0 || bus.cmd_op == 3'd7)
            state_d = S_DONE;
          else
            state_d = S_RUN;
        end
      end
      S_RUN: begin
        case (op_q)
          OP_XLOAD: begin
            issue         = 1'b1;
            bus.xmem_cen  = 1'b0;
            bus.xmem_wen  = 1'b0;
            bus.xmem_addr = x_at;
          end
          OP_L0FILL: begin
            bus.xmem_addr = x_at;
            if (!bus.l0_full) begin
              issue        = 1'b1;
              bus.xmem_cen = 1'b0;
            end
          end
          OP_KLOAD: begin
            issue     = 1'b1;
            bus.kload = 1'b1;
          end
          OP_EXEC: begin
            issue       = 1'b1;
            bus.execute = 1'b1;
          end
          OP_DRAIN: begin
            bus.pmem_addr = p_at;
            if (bus.ofifo_valid) begin
              issue        = 1'b1;
              bus.ofifo_rd = 1'b1;
              bus.pmem_cen = 1'b0;
              bus.pmem_wen = 1'b0;
            end
          end
          OP_READOUT: begin
            issue         = 1'b1;
            bus.pmem_cen  = 1'b0;
            bus.pmem_addr = p_at;
          end
          default: issue = 1'b1;
        endcase
        if (issue) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = (tail_len == '0) ? S_DONE : S_TAIL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_TAIL: begin
        bus.execute = (op_q == OP_EXEC);
        if (cnt_q == tail_len - 1'b1) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      mode_q  <= 1'b0;
      xbase_q <= '0;
      pbase_q <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      l0_wr_q <= 1'b0;
      sfp_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= 1'b1;
      // Read data arrives one cycle after the read; the strobe follows it.
      l0_wr_q <= (state_q == S_RUN) && (op_q == OP_L0FILL) && issue;
      sfp_q   <= (state_q == S_RUN) && (op_q == OP_READOUT) && issue;
      if (accept) begin
        op_q    <= op_e'(bus.cmd_op);
        mode_q  <= bus.cmd_mode;
        xbase_q <= bus.cmd_xbase;
        pbase_q <= bus.cmd_pbase;
        len_q   <= bus.cmd_len;
      end
    end
  end

  assign bus.l0_wr       = l0_wr_q;
  assign bus.sfp_valid   = sfp_q;
  assign bus.mode_select = mode_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign dbg_state_o     = state_q;

`ifdef CORE_SEQ_PERF_EN
  logic [31:0] perf_busy_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (state_q != S_IDLE && perf_busy_q != '1)
        perf_busy_q <= perf_busy_q + 32'd1;
      if (state_q == S_RUN && !issue && perf_stall_q != '1)
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_busy_cyc  = perf_busy_q;
  assign perf_stall_cyc = perf_stall_q;
`endif

endmodule

// File: tb/tb_core_seq.sv
// Self-checking bench for core_seq: directed table, event-level reference
// model of each command, reset corner cases and randomized commands.
module tb_core_seq;
  localparam int ROW = 8, COL = 8, AW = 11, LW = 12;
  localparam int MAXT = 4200;
  localparam int W = 35;
  localparam int B_XC = 0, B_XW = 1, B_PC = 2, B_PW = 3, B_L0 = 4, B_KL = 5;
  localparam int B_EX = 6, B_OR = 7, B_SF = 8, B_DN = 9, B_BZ = 10, B_RD = 11;
  localparam int B_MS = 12, XA = 13, PA = 24;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  core_seq_if #(.addr_w(AW), .len_w(LW)) bus ();

`ifdef CORE_SEQ_PERF_EN
  logic [31:0] perf_busy, perf_stall;
`endif

  core_seq #(.row(ROW), .col(COL), .addr_w(AW), .len_w(LW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
`ifdef CORE_SEQ_PERF_EN
    ,
    .perf_busy_cyc  (perf_busy),
    .perf_stall_cyc (perf_stall)
`endif
  );

  typedef struct {
    logic [2:0]    op;
    logic          mode;
    logic [AW-1:0] xb;
    logic [AW-1:0] pb;
    int            len;
    int            stall;
    int            lat;
  } vec_t;

  vec_t          tbl [13];
  int            checks = 0;
  int            failures = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  exp_a [0:MAXT];
  bit            full_pat [0:MAXT];
  bit            valid_pat [0:MAXT];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] sample();
    logic [W-1:0] s;
    s = '0;
    s[B_XC] = !bus.xmem_cen;
    s[B_XW] = !bus.xmem_wen;
    s[B_PC] = !bus.pmem_cen;
    s[B_PW] = !bus.pmem_wen;
    s[B_L0] = bus.l0_wr;
    s[B_KL] = bus.kload;
    s[B_EX] = bus.execute;
    s[B_OR] = bus.ofifo_rd;
    s[B_SF] = bus.sfp_valid;
    s[B_DN] = bus.done;
    s[B_BZ] = bus.busy;
    s[B_RD] = bus.cmd_ready;
    s[B_MS] = bus.mode_select;
    if (!bus.xmem_cen) s[XA +: AW] = bus.xmem_addr;
    if (!bus.pmem_cen) s[PA +: AW] = bus.pmem_addr;
    return s;
  endfunction

  // kind 0: never stalled, 1: l0_full on offsets 2..4, 2: ofifo_valid on odd
  // offsets, 3: random stalls for the first 200 offsets.
  task automatic set_pat(input int kind);
    for (int t = 0; t <= MAXT; t++) begin
      full_pat[t]  = 1'b0;
      valid_pat[t] = 1'b1;
      if (kind == 1) full_pat[t] = (t >= 2 && t <= 4);
      if (kind == 2) valid_pat[t] = (t % 2 == 1);
      if (kind == 3 && t < 200) begin
        full_pat[t]  = ($urandom_range(0, 2) == 0);
        valid_pat[t] = ($urandom_range(0, 2) != 0);
      end
    end
  endtask

  // Reference: expected observable events at each cycle offset after accept.
  task automatic build_exp(input logic [2:0] op, input logic mode, input logic [AW-1:0] xb,
                           input logic [AW-1:0] pb, input int len, output int d);
    int t, k, last, e;
    logic [AW-1:0] a;
    exp_q.delete();
    for (int i = 0; i <= MAXT; i++) exp_a[i] = '0;
    d = 1;
    if (len != 0 && op != 3'd0 && op != 3'd7) begin
      case (op)
        3'd1: begin
          for (k = 0; k < len; k++) begin
            a = xb + AW'(k);
            exp_a[k+1][B_XC] = 1'b1;
            exp_a[k+1][B_XW] = 1'b1;
            exp_a[k+1][XA +: AW] = a;
          end
          d = len + 1;
        end
        3'd2: begin
          t = 1; k = 0; last = 0;
          while (k < len && t < MAXT - 2) begin
            if (!full_pat[t]) begin
              a = xb + AW'(k);
              exp_a[t][B_XC] = 1'b1;
              exp_a[t][XA +: AW] = a;
              exp_a[t+1][B_L0] = 1'b1;
              k++;
              last = t;
            end
            t++;
          end
          d = last + 2;
        end
        3'd3: begin
          for (k = 1; k <= len; k++) exp_a[k][B_KL] = 1'b1;
          d = len + 1;
        end
        3'd4: begin
          e = len + (mode ? ROW + COL - 2 : 0);
          for (k = 1; k <= e; k++) exp_a[k][B_EX] = 1'b1;
          d = e + 1;
        end
        3'd5: begin
          t = 1; k = 0; last = 0;
          while (k < len && t < MAXT - 2) begin
            if (valid_pat[t]) begin
              a = pb + AW'(k);
              exp_a[t][B_PC] = 1'b1;
              exp_a[t][B_PW] = 1'b1;
              exp_a[t][B_OR] = 1'b1;
              exp_a[t][PA +: AW] = a;
              k++;
              last = t;
            end
            t++;
          end
          d = last + 1;
        end
        default: begin
          for (k = 0; k < len; k++) begin
            a = pb + AW'(k);
            exp_a[k+1][B_PC] = 1'b1;
            exp_a[k+1][PA +: AW] = a;
            exp_a[k+2][B_SF] = 1'b1;
          end
          d = len + 2;
        end
      endcase
    end
    for (t = 1; t <= d; t++) begin
      exp_a[t][B_BZ] = 1'b1;
      exp_a[t][B_MS] = mode;
    end
    exp_a[d][B_DN] = 1'b1;
    for (t = 1; t <= d; t++) exp_q.push_back(exp_a[t]);
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic mode, input logic [AW-1:0] xb,
                         input logic [AW-1:0] pb, input int len, output int done_off);
    int d;
    logic [W-1:0] got, e;
    build_exp(op, mode, xb, pb, len, d);
    @(negedge clk);
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = op;
    bus.cmd_mode    = mode;
    bus.cmd_xbase   = xb;
    bus.cmd_pbase   = pb;
    bus.cmd_len     = LW'(len);
    bus.l0_full     = full_pat[0];
    bus.ofifo_valid = valid_pat[0];
    #1;
    check("accept_ready", bus.cmd_ready, 1);
    done_off = -1;
    for (int t = 1; t <= d; t++) begin
      @(negedge clk);
      // Commands offered while busy must be ignored.
      bus.cmd_valid   = 1'($urandom_range(0, 1));
      bus.cmd_op      = 3'($urandom_range(0, 7));
      bus.cmd_len     = LW'($urandom_range(1, 9));
      bus.cmd_mode    = 1'($urandom_range(0, 1));
      bus.l0_full     = full_pat[t];
      bus.ofifo_valid = valid_pat[t];
      #1;
      got = sample();
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL cyc op=%0d t=%0d got=%h exp=%h", op, t, got, e);
      end
      if (got[B_DN] && done_off < 0) done_off = t;
    end
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    int lat;
    logic [2:0] rop;
    logic [AW-1:0] pbx;
`ifdef CORE_SEQ_PERF_EN
    logic [31:0] snap;
`endif
    tbl[0]  = '{3'd1, 1'b0, 11'h7FE, 11'h000, 4,    0, 5};
    tbl[1]  = '{3'd2, 1'b0, 11'h100, 11'h000, 6,    1, 11};
    tbl[2]  = '{3'd4, 1'b1, 11'h000, 11'h000, 5,    0, 20};
    tbl[3]  = '{3'd4, 1'b0, 11'h000, 11'h000, 5,    0, 6};
    tbl[4]  = '{3'd5, 1'b0, 11'h000, 11'h040, 3,    2, 6};
    tbl[5]  = '{3'd6, 1'b0, 11'h000, 11'h123, 0,    0, 1};
    tbl[6]  = '{3'd3, 1'b1, 11'h000, 11'h000, 3,    0, 4};
    tbl[7]  = '{3'd6, 1'b0, 11'h000, 11'h7FF, 4,    0, 6};
    tbl[8]  = '{3'd0, 1'b0, 11'h000, 11'h000, 5,    0, 1};
    tbl[9]  = '{3'd7, 1'b1, 11'h000, 11'h000, 3,    0, 1};
    tbl[10] = '{3'd2, 1'b0, 11'h3F0, 11'h000, 2,    0, 4};
    tbl[11] = '{3'd5, 1'b1, 11'h000, 11'h7FD, 4,    0, 5};
    tbl[12] = '{3'd1, 1'b0, 11'h7F0, 11'h000, 4095, 0, 4096};

    // Clock/reset
    reset           = 1'b0;
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = '0;
    bus.cmd_mode    = 1'b0;
    bus.cmd_xbase   = '0;
    bus.cmd_pbase   = '0;
    bus.cmd_len     = '0;
    bus.l0_full     = 1'b0;
    bus.ofifo_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_state", 64'(sample()), 64'd0);
    check("reset_wen_addr", {bus.xmem_wen, bus.pmem_wen, bus.xmem_addr, bus.pmem_addr},
          {2'b11, 22'd0});
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("ready_after_reset", bus.cmd_ready, 1);

    for (int i = 0; i < 13; i++) begin
      set_pat(tbl[i].stall);
      run_cmd(tbl[i].op, tbl[i].mode, tbl[i].xb, tbl[i].pb, tbl[i].len, lat);
      check($sformatf("done_lat_%0d", i), 64'(lat), 64'(tbl[i].lat));
    end

`ifdef CORE_SEQ_PERF_EN
    set_pat(0);
    @(negedge clk);
    snap = perf_busy;
    run_cmd(3'd6, 1'b0, 11'h0, 11'h0, 0, lat);
    @(negedge clk);
    #1;
    check("perf_busy_len0", perf_busy, snap + 32'd1);
`endif

    // Reset in the middle of DRAIN, beat 3 of 8.
    set_pat(0);
    pbx = 11'h200;
    @(negedge clk);
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = 3'd5;
    bus.cmd_mode    = 1'b0;
    bus.cmd_pbase   = pbx;
    bus.cmd_len     = 12'd8;
    bus.ofifo_valid = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      #1;
      if (t == 2) check("drain_pre_reset", {!bus.pmem_cen, bus.pmem_addr}, {1'b1, pbx + 11'd1});
    end
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("reset_mid_drain", {bus.pmem_cen, bus.ofifo_rd, bus.busy, bus.cmd_ready}, 4'b1000);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("ready_after_mid_reset", bus.cmd_ready, 1);

    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      set_pat(3);
      run_cmd(rop, 1'($urandom_range(0, 1)), AW'($urandom), AW'($urandom),
              $urandom_range(0, 24), lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/core_seq.md
# core_seq

Parametrised, command-driven sequencer for the systolic core. It replaces the per-cycle instruction stream that the testbench previously supplied. It accepts one high-level command at a time (load activations, fill L0, load kernel, execute, drain OFIFO to psum memory, read out psum memory), generates all activation-SRAM and psum-SRAM strobes and addresses itself, and stalls on the L0/OFIFO flow-control flags. It supports both weight-stationary (WS) and output-stationary (OS) dataflows, and sits between the host command port and the corelet/SRAM pair inside the core.

## Interface
- row, 8, PE array rows (L0 channels)
- col, 8, PE array columns
- addr_w, 11, SRAM address width (depth 2^addr_w)
- len_w, 12, command length field width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
- cmd_op  in  3  0 NOP, 1 XLOAD, 2 L0FILL, 3 KLOAD, 4 EXEC, 5 DRAIN, 6 READOUT, 7 reserved (treated as NOP)
- cmd_mode  in  1  0 = WS, 1 = OS; latched at accept
- cmd_xbase  in  addr_w  activation SRAM base address
- cmd_pbase  in  addr_w  psum SRAM base address
- cmd_len  in  len_w  beat count
- l0_full  in  1  L0 has at most one free entry
- ofifo_valid  in  1  OFIFO holds a complete row
- xmem_cen, xmem_wen  out  1  activation SRAM strobes, active-low
- xmem_addr  out  addr_w  activation SRAM address
- pmem_cen, pmem_wen  out  1  psum SRAM strobes, active-low
- pmem_addr  out  addr_w  psum SRAM address
- l0_wr  out  1  push SRAM read data into L0
- kload  out  1  kernel load strobe to PE array
- execute  out  1  execute strobe to PE array
- ofifo_rd  out  1  pop OFIFO
- sfp_valid  out  1  psum SRAM read data valid at SFP input
- mode_select  out  1  latched mode
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, RUN, TAIL, DONE.
- IDLE -> RUN on cmd_valid && cmd_ready. The sequencer latches op, mode, bases and len, and clears the beat counter i. If len == 0 or op is NOP/reserved, the FSM goes IDLE -> DONE directly, with no strobes.
- RUN behaviour per op, with address = base + i modulo 2^addr_w (wrap-around is legal and silent):
  - XLOAD: xmem_cen = xmem_wen = 0, address xbase+i, one beat per cycle.
  - L0FILL: xmem read (cen = 0, wen = 1) issued only when !l0_full. i advances only on an issued read. l0_wr is asserted exactly one cycle after each issued read.
  - KLOAD: kload = 1 for len cycles; no SRAM access.
  - EXEC: execute = 1 for len cycles. In OS mode, execute is additionally held for row+col-2 further cycles in TAIL (accumulation flush).
  - DRAIN: when ofifo_valid, ofifo_rd = 1 and pmem write at pbase+i in the same cycle; i advances. No ofifo_valid means stall with pmem_cen = 1.
  - READOUT: pmem read at pbase+i. sfp_valid follows one cycle after each read.
- RUN -> TAIL after the last beat is issued. TAIL holds until the last delayed strobe (l0_wr / sfp_valid / OS flush) has completed, then goes to DONE.
- DONE: done = 1 for one cycle, then IDLE.
- Inactive levels: cen = wen = 1, all other strobes 0, addresses 0.

## Timing
- Reset (reset == 0 at a rising edge) forces IDLE from any state in that cycle; a command in progress is abandoned.
- Output values on reset:
  - cmd_ready = 0 during reset, 1 the cycle after release.
  - All strobes at their inactive levels.
  - Addresses 0; mode_select, busy and done all 0.
- Acceptance: the first strobe appears in the cycle after acceptance.
- Latency from accept to done, unstalled, len = N:
  - XLOAD, KLOAD, DRAIN: N+1 cycles.
  - L0FILL, READOUT: N+2 cycles.
  - EXEC: N+1 cycles in WS, N+row+col-1 cycles in OS.
- busy = 1 from the cycle after accept through DONE inclusive.
- cmd_valid while busy is ignored; cmd_ready = 0.
- Stall rules:
  - An l0_full or !ofifo_valid stall holds the address and the counter.
  - l0_full asserted in the cycle after a read does not suppress the pending l0_wr.
- len at its maximum (2^len_w - 1) with a base near the top of memory wraps the address to 0.

## Configuration
- CORE_SEQ_PERF_EN defined: adds outputs perf_busy_cyc[31:0] (cycles with busy = 1) and perf_stall_cyc[31:0] (RUN cycles with no beat issued). Both are saturating, cleared by reset, and held across commands.
- CORE_SEQ_PERF_EN undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset mid-DRAIN at beat 3 of 8 -> next cycle: IDLE, pmem_cen = 1, ofifo_rd = 0, busy = 0; cmd_ready = 1 after release.
- XLOAD, xbase = 0x7FE, len = 4 -> writes to 0x7FE, 0x7FF, 0x000, 0x001; done at accept+5.
- L0FILL, len = 6, l0_full high for cycles 2–4 -> exactly 6 reads and 6 l0_wr pulses, each l0_wr 1 cycle after its read; no read issued while l0_full.
- EXEC, len = 5, OS, row = col = 8 -> execute high for 19 cycles; done at accept+20. Same command in WS -> execute high 5 cycles, done at accept+6.
- DRAIN, len = 3, ofifo_valid toggling 1,0,1,0,1 -> pmem writes to pbase, pbase+1, pbase+2 only on valid cycles; cmd_valid during DRAIN is ignored.
- len = 0 READOUT -> no pmem access; done at accept+1. With CORE_SEQ_PERF_EN: perf_busy_cyc increments by 1.
